// File: rtl/myproject_mac_pkg.sv
// Shared types and helpers for the dense MAC accumulator: product width,
// FSM state encoding and the output saturation function.
package myproject_mac_pkg;

    localparam int PROD_W = 9;

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        HOLD
    } state_t;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] val;
    } sat_t;

    // Clamp a wide signed sum into an out_width-bit signed range.
    function automatic sat_t sat_signed(input logic signed [63:0] sum, input int out_width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_t               res;
        max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v   = -max_v - 64'sd1;
        res.ovf = 1'b1;
        if (sum > max_v) begin
            res.val = max_v;
        end else if (sum < min_v) begin
            res.val = min_v;
        end else begin
            res.val = sum;
            res.ovf = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/myproject_mul_3ns_6s_9_1_0.sv
// Combinational unsigned-by-signed multiplier core (3-bit unsigned x 6-bit signed -> 9-bit).
module myproject_mul_3ns_6s_9_1_0 #(
    parameter int din0_WIDTH = 3,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 9
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    logic signed [dout_WIDTH-1:0] a_ext;
    logic signed [dout_WIDTH-1:0] b_ext;

    // din0 is zero-extended (unsigned), din1 sign-extended; the low dout bits are exact.
    assign a_ext = {{(dout_WIDTH - din0_WIDTH){1'b0}}, din0};
    assign b_ext = {{(dout_WIDTH - din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
    assign dout  = a_ext * b_ext;

endmodule

// File: rtl/myproject_dense_mac_acc.sv
// Streaming dot-product stage: accumulates one frame of activation*weight
// products, adds a bias, saturates and hands the result out over valid/ready.
module myproject_dense_mac_acc
    import myproject_mac_pkg::*;
#(
    parameter int N_IN      = 16,
    parameter int ACC_WIDTH = 16,
    parameter int OUT_WIDTH = 12
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [2:0]           in_data,
    input  logic [5:0]           in_weight,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACC_WIDTH-1:0] bias,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CNT_W = $clog2(N_IN) + 1;

    state_t                      state_reg, state_next;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic [PROD_W-1:0]           prod_reg;
    logic                        prod_vld_reg;
    logic [CNT_W-1:0]            cnt_reg;
    logic [OUT_WIDTH-1:0]        out_data_reg;
    logic                        out_ovf_reg;
    logic                        out_valid_reg;

    logic [PROD_W-1:0]           product;
    logic                        accept;
    logic                        close;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [63:0]          sum_ext;
    sat_t                        sat_res;
    logic [63-OUT_WIDTH:0]       sat_hi_unused;

    myproject_mul_3ns_6s_9_1_0 #(
        .din0_WIDTH (3),
        .din1_WIDTH (6),
        .dout_WIDTH (PROD_W)
    ) u_mul (
        .din0 (in_data),
        .din1 (in_weight),
        .dout (product)
    );

    assign in_ready = (state_reg == ACC);
    assign accept   = in_valid & in_ready;
    assign close    = accept & (in_last | (cnt_reg == CNT_W'(N_IN - 1)));

    // The last captured product is still in prod_reg during FLUSH, so it joins the final sum here.
    assign prod_ext = {{(ACC_WIDTH - PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
    assign sum      = {acc_reg[ACC_WIDTH-1], acc_reg}
                    + {prod_ext[ACC_WIDTH-1], prod_ext}
                    + {bias[ACC_WIDTH-1], bias};
    assign sum_ext  = {{(63 - ACC_WIDTH){sum[ACC_WIDTH]}}, sum};
    assign sat_res  = sat_signed(sum_ext, OUT_WIDTH);
    // Upper bits of the clamped value are only sign copies.
    assign sat_hi_unused = sat_res.val[63:OUT_WIDTH];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACC:     if (close) state_next = FLUSH;
            FLUSH:   state_next = HOLD;
            HOLD:    if (out_valid_reg && out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg     <= ACC;
            acc_reg       <= '0;
            prod_reg      <= '0;
            prod_vld_reg  <= 1'b0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ACC: begin
                    if (accept) begin
                        prod_reg <= product;
                        cnt_reg  <= cnt_reg + CNT_W'(1);
                    end
                    prod_vld_reg <= accept;
                    if (prod_vld_reg) acc_reg <= acc_reg + prod_ext;
                end
                FLUSH: begin
                    out_data_reg  <= sat_res.val[OUT_WIDTH-1:0];
                    out_ovf_reg   <= sat_res.ovf;
                    out_valid_reg <= 1'b1;
                    prod_vld_reg  <= 1'b0;
                end
                HOLD: begin
                    if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        acc_reg       <= '0;
                        cnt_reg       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_valid = out_valid_reg;

endmodule
